clk_switch_ctrl: RTL and testbench



---
 rtl/clk_switch_ctrl.sv | 86 ++++++++
 tb/tb_clk_switch_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: glitch-free select/enable sequencer for a 4:1 PLL clock mux and gate.
// Define CLK_SWITCH_SKIP_SAME_EN to accept same-source requests without a gating sequence.
module clk_switch_ctrl #(
    parameter int         GATE_OFF_CYCLES = 4,
    parameter int         SETTLE_CYCLES   = 8,
    parameter logic [1:0] RESET_SEL       = 2'd0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    input  logic [1:0] req_sel_i,
    output logic       req_ready_o,
    input  logic       en_req_i,
    output logic [1:0] sel_o,
    output logic       en_o,
    output logic       busy_o,
    output logic       done_o
);
    localparam int MAXC = (GATE_OFF_CYCLES > SETTLE_CYCLES) ? GATE_OFF_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, GATE_OFF, SETTLE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      sel_q, pend_q;
    logic            en_q, done_q, same;

`ifdef CLK_SWITCH_SKIP_SAME_EN
    assign same = (req_sel_i == sel_q);
`else
    assign same = 1'b0;
`endif

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign sel_o       = sel_q;
    assign en_o        = en_q;
    assign done_o      = done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= RESET_SEL;
            pend_q  <= RESET_SEL;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i && !same) begin
                        pend_q  <= req_sel_i;
                        en_q    <= 1'b0;
                        cnt_q   <= CW'(GATE_OFF_CYCLES - 1);
                        state_q <= GATE_OFF;
                    end else begin
                        en_q   <= en_req_i;
                        done_q <= req_valid_i && same;
                    end
                end
                GATE_OFF: begin
                    en_q <= 1'b0;
                    if (cnt_q == '0) begin
                        sel_q   <= pend_q;
                        cnt_q   <= CW'(SETTLE_CYCLES - 1);
                        state_q <= SETTLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        en_q    <= en_req_i;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: directed self-checking bench for clk_switch_ctrl with default parameters.
module tb_clk_switch_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [1:0] rsel = 2'd0;
    logic       en_req = 1'b0;
    logic       ready, en, busy, done;
    logic [1:0] sel;
    int         total = 0;
    int         passed = 0;

    clk_switch_ctrl dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_sel_i(rsel),
        .req_ready_o(ready), .en_req_i(en_req), .sel_o(sel), .en_o(en),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Caller presents the request; first tick is the accept edge, then cycles 1..13 are checked.
    task automatic seq(input logic [1:0] o, input logic [1:0] n, input logic e,
                       input int h, input logic [1:0] hs, input bit t);
        tick();
        valid = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            check($sformatf("en_c%0d", k),    en,    (k == 13) ? e : 1'b0);
            check($sformatf("sel_c%0d", k),   sel,   (k <= 4) ? o : n);
            check($sformatf("done_c%0d", k),  done,  k == 13);
            check($sformatf("busy_c%0d", k),  busy,  k <= 12);
            check($sformatf("ready_c%0d", k), ready, k == 13);
            if (k == h) begin
                valid = 1'b1;
                rsel  = hs;
            end
            if (t && (k == 6 || k == 8 || k == 10)) en_req = ~en_req;
            if (k < 13) tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        rst    = 1'b0;
        en_req = 1'b1;
        check("rst_sel", sel, 2'd0);
        check("rst_en", en, 1'b0);
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        tick();
        check("en_follow", en, 1'b1);

        valid = 1'b1;
        rsel  = 2'd2;
        seq(2'd0, 2'd2, 1'b1, 0, 2'd0, 1'b0);

        en_req = 1'b0;
        valid  = 1'b1;
        rsel   = 2'd1;
        seq(2'd2, 2'd1, 1'b0, 6, 2'd3, 1'b0);
        seq(2'd1, 2'd3, 1'b1, 0, 2'd0, 1'b1);

        en_req = 1'b0;
        tick();
        check("en_follow_lo", en, 1'b0);
        en_req = 1'b1;
        tick();
        check("en_follow_hi", en, 1'b1);

        valid = 1'b1;
        rsel  = 2'd1;
        tick();
        valid = 1'b0;
        repeat (6) tick();
        check("mid_sel", sel, 2'd1);
        check("mid_en", en, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_sel", sel, 2'd0);
        check("mrst_en", en, 1'b0);
        check("mrst_ready", ready, 1'b1);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        for (int i = 0; i < 13; i++) begin
            tick();
            check($sformatf("mrst_nodone%0d", i), done, 1'b0);
            check($sformatf("mrst_selk%0d", i), sel, 2'd0);
        end
        check("mrst_en_after", en, 1'b1);

        valid = 1'b1;
        rsel  = 2'd1;
        seq(2'd0, 2'd1, 1'b1, 0, 2'd0, 1'b0);
        valid = 1'b1;
        rsel  = 2'd1;
`ifdef CLK_SWITCH_SKIP_SAME_EN
        tick();
        valid = 1'b0;
        check("same_done", done, 1'b1);
        check("same_en", en, 1'b1);
        check("same_busy", busy, 1'b0);
        check("same_sel", sel, 2'd1);
        tick();
        check("same_done_end", done, 1'b0);
        check("same_en_end", en, 1'b1);
`else
        seq(2'd1, 2'd1, 1'b1, 0, 2'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
